// File: rtl/coinc_histogrammer_pkg.sv
// Shared types and default sizes for the coincidence histogrammer.
// Saturating counters are selected by defining HIST_SATURATE_EN.
package hist_pkg;

    localparam int NBINS_DEF = 32;
    localparam int CNT_W_DEF = 32;
    localparam int IDX_W     = 5;

    typedef logic [CNT_W_DEF-1:0] hist_cnt_t;
    typedef logic [IDX_W-1:0]     hist_idx_t;

endpackage

// File: rtl/coinc_histogrammer_edge_counter.sv
// Rising-edge counter for one firing output: edge detect, one pipeline stage,
// clear/reset handling and, with HIST_SATURATE_EN, saturation reporting.
module edge_counter
    import hist_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_sig,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_cnt
`ifdef HIST_SATURATE_EN
    ,
    output logic             o_sat_hit
`endif
);

    logic             r_sig_d;
    logic             r_s1_edge;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sig_d   <= 1'b0;
            r_s1_edge <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sig_d   <= i_sig;
            r_s1_edge <= i_sig & ~r_sig_d;
            // Clear wins over an increment landing on the same edge.
            if (i_clear) begin
                r_cnt <= '0;
            end else if (r_s1_edge) begin
`ifdef HIST_SATURATE_EN
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
`else
                r_cnt <= r_cnt + CNT_W'(1);
`endif
            end
        end
    end

    assign o_cnt = r_cnt;

`ifdef HIST_SATURATE_EN
    assign o_sat_hit = r_s1_edge & (&r_cnt) & ~i_clear;
`endif

endmodule

// File: rtl/coinc_histogrammer.sv
// Coincidence-pattern histogram (NBINS bins) plus two fire edge counters.
// Define HIST_SATURATE_EN for saturating counters and a sticky overflow flag.
module coinc_histogrammer
    import hist_pkg::*;
#(
    parameter int NBINS = NBINS_DEF,
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        hit_valid,
    input  hist_idx_t                   hit_pattern,
    input  logic [1:0]                  fire,
    input  logic                        resethist,
    output logic [NBINS-1:0][CNT_W-1:0] h,
    output logic [1:0][CNT_W-1:0]       h_out,
    output logic                        overflow
);

    logic                        r_s1_valid;
    hist_idx_t                   r_s1_idx;
    logic [NBINS-1:0][CNT_W-1:0] r_h;
    logic [NBINS-1:0]            w_bin_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= hit_valid;
            r_s1_idx   <= hit_pattern;
        end
    end

    always_comb begin
        w_bin_we = '0;
        for (int i = 0; i < NBINS; i++) begin
            w_bin_we[i] = r_s1_valid && (r_s1_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h <= '0;
        end else if (resethist) begin
            r_h <= '0;
        end else begin
            for (int i = 0; i < NBINS; i++) begin
                if (w_bin_we[i]) begin
`ifdef HIST_SATURATE_EN
                    if (r_h[i] != '1) begin
                        r_h[i] <= r_h[i] + CNT_W'(1);
                    end
`else
                    r_h[i] <= r_h[i] + CNT_W'(1);
`endif
                end
            end
        end
    end

    assign h = r_h;

`ifdef HIST_SATURATE_EN
    logic       w_bin_sat;
    logic [1:0] w_fire_sat;
    logic       r_overflow;

    edge_counter #(.CNT_W(CNT_W)) u_fire0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_sig     (fire[0]),
        .i_clear   (resethist),
        .o_cnt     (h_out[0]),
        .o_sat_hit (w_fire_sat[0])
    );

    edge_counter #(.CNT_W(CNT_W)) u_fire1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_sig     (fire[1]),
        .i_clear   (resethist),
        .o_cnt     (h_out[1]),
        .o_sat_hit (w_fire_sat[1])
    );

    // An increment attempted on a full bin is what flags overflow.
    always_comb begin
        w_bin_sat = 1'b0;
        for (int i = 0; i < NBINS; i++) begin
            if (w_bin_we[i] && (&r_h[i])) begin
                w_bin_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (resethist) begin
            r_overflow <= 1'b0;
        end else if (w_bin_sat || (|w_fire_sat)) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    edge_counter #(.CNT_W(CNT_W)) u_fire0 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sig   (fire[0]),
        .i_clear (resethist),
        .o_cnt   (h_out[0])
    );

    edge_counter #(.CNT_W(CNT_W)) u_fire1 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_sig   (fire[1]),
        .i_clear (resethist),
        .o_cnt   (h_out[1])
    );

    assign overflow = 1'b0;
`endif

endmodule
